multicycle_control: RTL

Multi-cycle LEGv8 control unit. Sequences the shared datapath (register file, ALU, sign extender, unified memory, PC/IR/ALUOut registers) through fetch, decode, execute, memory and writeback, one instruction at a time. Sits beside the datapath in the multi-cycle processor top level. Drives every mux select, write enable and the sign-extender mode. Waits on a memory-ready handshake for every memory access.

---
 rtl/legv8_pkg.sv | 68 ++++++
 rtl/multicycle_control_opcode_class.sv | 46 ++++
 rtl/multicycle_control.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: FSM states, opcode classes and encodings,
// and the control-word layout used by the multi-cycle control unit.
package legv8_pkg;

    typedef enum logic [3:0] {
        S_START, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
        S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BR, S_CBZ, S_ILLEGAL
    } state_e;

    typedef enum logic [2:0] {
        C_R, C_I, C_D_LD, C_D_ST, C_B, C_CBZ, C_BAD
    } op_class_e;

    localparam logic [10:0] OP_ADD    = 11'b10001011000;
    localparam logic [10:0] OP_SUB    = 11'b11001011000;
    localparam logic [10:0] OP_AND    = 11'b10001010000;
    localparam logic [10:0] OP_ORR    = 11'b10101010000;
    localparam logic [10:0] OP_ADDI   = 11'b10010001000;
    localparam logic [10:0] OP_SUBI   = 11'b11010001000;
    localparam logic [10:0] OP_LDUR   = 11'b11111000010;
    localparam logic [10:0] OP_STUR   = 11'b11111000000;
    localparam logic [10:0] OP_B      = 11'b00010100000;
    localparam logic [10:0] OP_CBZ    = 11'b10110100000;
    localparam logic [10:0] MASK_FULL = 11'b11111111111;
    localparam logic [10:0] MASK_I    = 11'b11111111110;
    localparam logic [10:0] MASK_B    = 11'b11111100000;
    localparam logic [10:0] MASK_CBZ  = 11'b11111111000;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ORR  = 4'b0001;
    localparam logic [3:0] ALU_PASS = 4'b0111;

    localparam logic [1:0] SIGN_I   = 2'b00;
    localparam logic [1:0] SIGN_D   = 2'b01;
    localparam logic [1:0] SIGN_B   = 2'b10;
    localparam logic [1:0] SIGN_CBZ = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       regwrite;
        logic       memtoreg;
        logic       reg2loc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       pcsource;
        logic [3:0] aluctrl;
        logic [1:0] signop;
        logic       done;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] val,
                                      input logic [10:0] mask);
        return ((op & mask) == (val & mask));
    endfunction

endpackage

// File: rtl/multicycle_control_opcode_class.sv
// Combinational opcode classifier: maps IR[31:21] to an instruction class and
// the ALU function used by the R- and I-type execute states.
module opcode_class
    import legv8_pkg::*;
(
    input  logic [10:0] opcode,
    output op_class_e   op_class,
    output logic [3:0]  alu_fn
);

    // Classify opcode and select ALU function
    always_comb begin
        op_class = C_BAD;
        alu_fn   = ALU_ADD;
        if (op_match(opcode, OP_ADD, MASK_FULL)) begin
            op_class = C_R;
            alu_fn   = ALU_ADD;
        end else if (op_match(opcode, OP_SUB, MASK_FULL)) begin
            op_class = C_R;
            alu_fn   = ALU_SUB;
        end else if (op_match(opcode, OP_AND, MASK_FULL)) begin
            op_class = C_R;
            alu_fn   = ALU_AND;
        end else if (op_match(opcode, OP_ORR, MASK_FULL)) begin
            op_class = C_R;
            alu_fn   = ALU_ORR;
        end else if (op_match(opcode, OP_ADDI, MASK_I)) begin
            op_class = C_I;
            alu_fn   = ALU_ADD;
        end else if (op_match(opcode, OP_SUBI, MASK_I)) begin
            op_class = C_I;
            alu_fn   = ALU_SUB;
        end else if (op_match(opcode, OP_LDUR, MASK_FULL)) begin
            op_class = C_D_LD;
        end else if (op_match(opcode, OP_STUR, MASK_FULL)) begin
            op_class = C_D_ST;
        end else if (op_match(opcode, OP_B, MASK_B)) begin
            op_class = C_B;
        end else if (op_match(opcode, OP_CBZ, MASK_CBZ)) begin
            op_class = C_CBZ;
        end else begin
            op_class = C_BAD;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control FSM. State-decoded controls are registered; only
// the memory-handshake strobes and decode-cycle selects look at live inputs.
module multicycle_control
    import legv8_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [10:0] Opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IRWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        Reg2Loc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        PCSource,
    output logic [3:0]  ALUCtrl,
    output logic [1:0]  SignOp,
    output logic        Done,
    output logic        Illegal
);

    state_e    state_r;
    state_e    next_s;
    ctrl_t     ctrl_r;
    logic      arm_r;
    op_class_e cls_s;
    logic [3:0] alu_fn_s;
    logic      fetch_s;
    logic      decode_s;
    logic      memwr_s;
    logic      unused_s;

    opcode_class u_class (
        .opcode   (Opcode),
        .op_class (cls_s),
        .alu_fn   (alu_fn_s)
    );

    // Zero is consumed by the datapath together with PCWriteCond
    assign unused_s = Zero;

    function automatic ctrl_t state_ctrl(input state_e s, input logic [3:0] fn);
        ctrl_t c;
        c = '0;
        c.aluctrl = ALU_ADD;
        case (s)
            S_START:    c = '0;
            S_FETCH:    begin c.memread = 1'b1; c.alusrcb = SRCB_FOUR; end
            S_DECODE:   c.alusrcb = SRCB_IMM;
            S_EXEC_R:   begin c.alusrca = 1'b1; c.alusrcb = SRCB_REG; c.aluctrl = fn; end
            S_EXEC_I:   begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; c.aluctrl = fn; end
            S_WB_ALU:   begin c.regwrite = 1'b1; c.done = 1'b1; end
            S_MEM_ADDR: begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; c.signop = SIGN_D; end
            S_MEM_RD:   begin c.memread = 1'b1; c.iord = 1'b1; end
            S_WB_MEM:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.done = 1'b1; end
            S_MEM_WR:   begin c.memwrite = 1'b1; c.iord = 1'b1; c.reg2loc = 1'b1; end
            S_BR:       begin c.pcwrite = 1'b1; c.pcsource = 1'b1; c.done = 1'b1; end
            S_CBZ: begin
                c.alusrca     = 1'b1;
                c.alusrcb     = SRCB_REG;
                c.reg2loc     = 1'b1;
                c.aluctrl     = ALU_PASS;
                c.pcwritecond = 1'b1;
                c.pcsource    = 1'b1;
                c.done        = 1'b1;
            end
            S_ILLEGAL:  begin c = '0; c.illegal = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_START:    if (arm_r) next_s = S_FETCH; else next_s = S_START;
            S_FETCH:    if (MemReady) next_s = S_DECODE; else next_s = S_FETCH;
            S_DECODE: begin
                case (cls_s)
                    C_R:            next_s = S_EXEC_R;
                    C_I:            next_s = S_EXEC_I;
                    C_D_LD, C_D_ST: next_s = S_MEM_ADDR;
                    C_B:            next_s = S_BR;
                    C_CBZ:          next_s = S_CBZ;
                    default:        next_s = S_ILLEGAL;
                endcase
            end
            S_EXEC_R, S_EXEC_I: next_s = S_WB_ALU;
            S_MEM_ADDR: if (cls_s == C_D_ST) next_s = S_MEM_WR; else next_s = S_MEM_RD;
            S_MEM_RD:   if (MemReady) next_s = S_WB_MEM; else next_s = S_MEM_RD;
            S_MEM_WR:   if (MemReady) next_s = S_FETCH; else next_s = S_MEM_WR;
            S_WB_ALU, S_WB_MEM, S_BR, S_CBZ: next_s = S_FETCH;
            S_ILLEGAL:  next_s = S_ILLEGAL;
            default:    next_s = S_START;
        endcase
    end

    // State and registered control word; arm_r holds START for one full cycle after reset release
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_r <= S_START;
            ctrl_r  <= '0;
            arm_r   <= 1'b0;
        end else begin
            state_r <= next_s;
            ctrl_r  <= state_ctrl(next_s, alu_fn_s);
            arm_r   <= 1'b1;
        end
    end

    assign fetch_s  = (state_r == S_FETCH);
    assign decode_s = (state_r == S_DECODE);
    assign memwr_s  = (state_r == S_MEM_WR);

    // The opcode is only valid once DECODE is entered, so its selects are live
    assign IRWrite     = fetch_s & MemReady;
    assign PCWrite     = ctrl_r.pcwrite | (fetch_s & MemReady);
    assign Done        = ctrl_r.done | (memwr_s & MemReady);
    assign Reg2Loc     = ctrl_r.reg2loc | (decode_s & ((cls_s == C_D_ST) | (cls_s == C_CBZ)));
    assign SignOp      = decode_s ? ((cls_s == C_B) ? SIGN_B : SIGN_CBZ) : ctrl_r.signop;
    assign PCWriteCond = ctrl_r.pcwritecond;
    assign MemRead     = ctrl_r.memread;
    assign MemWrite    = ctrl_r.memwrite;
    assign IorD        = ctrl_r.iord;
    assign RegWrite    = ctrl_r.regwrite;
    assign MemtoReg    = ctrl_r.memtoreg;
    assign ALUSrcA     = ctrl_r.alusrca;
    assign ALUSrcB     = ctrl_r.alusrcb;
    assign PCSource    = ctrl_r.pcsource;
    assign ALUCtrl     = ctrl_r.aluctrl;
    assign Illegal     = ctrl_r.illegal;

endmodule
